// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: decodes ALU control and operands for the execute-stage ALU
// and holds them in the ID/EX register behind a valid/ready handshake with stall and flush.
module alu_decode_stage #(
  parameter bit CHECK_FUNCT7 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] data_A,
  output logic [31:0] data_B,
  output logic [31:0] store_data,
  output logic [4:0]  rd_addr,
  output logic        reg_write,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic [2:0]  br_funct3,
  output logic        illegal,
  output logic [31:0] pc_out
);
  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            funct7_bad;
  logic            accept;
  logic            unused_rs1_idx;
  logic [3:0]      f3_ctrl;
  logic [3:0]      d_ctrl;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic            d_we;
  logic            d_ld;
  logic            d_st;
  logic            d_br;
  logic            d_ill;

  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];
  assign imm_i          = {{20{instr[31]}}, instr[31:20]};
  assign imm_s          = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u          = {instr[31:12], 12'b0};
  assign shamt          = {27'b0, instr[24:20]};
  assign unused_rs1_idx = ^instr[19:15];
  assign funct7_bad     = CHECK_FUNCT7 && (funct7 != 7'h00) && (funct7 != 7'h20);

  // Base funct3 -> ALU op map shared by OP and OP-IMM; SUB/SRA picked later.
  always_comb begin
    f3_ctrl = ALU_ADD;
    case (funct3)
      3'd0: f3_ctrl = ALU_ADD;
      3'd1: f3_ctrl = ALU_SLL;
      3'd2: f3_ctrl = ALU_SLT;
      3'd3: f3_ctrl = ALU_SLTU;
      3'd4: f3_ctrl = ALU_XOR;
      3'd5: f3_ctrl = ALU_SRL;
      3'd6: f3_ctrl = ALU_OR;
      3'd7: f3_ctrl = ALU_AND;
      default: f3_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    d_ctrl = ALU_ADD;
    d_a    = '0;
    d_b    = '0;
    d_we   = 1'b0;
    d_ld   = 1'b0;
    d_st   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_a    = rs1_data;
        d_b    = rs2_data;
        d_we   = 1'b1;
        d_ctrl = f3_ctrl;
        if (funct7[5] && funct3 == 3'd0) d_ctrl = ALU_SUB;
        if (funct7[5] && funct3 == 3'd5) d_ctrl = ALU_SRA;
        d_ill  = funct7_bad || (funct7[5] && funct3 != 3'd0 && funct3 != 3'd5);
      end
      OPC_OP_IMM: begin
        d_a    = rs1_data;
        d_b    = imm_i;
        d_we   = 1'b1;
        d_ctrl = f3_ctrl;
        if (funct3 == 3'd1 || funct3 == 3'd5) begin
          d_b   = shamt;
          d_ill = funct7_bad || (funct3 == 3'd1 && instr[30]);
          if (funct3 == 3'd5 && instr[30]) d_ctrl = ALU_SRA;
        end
      end
      OPC_LUI: begin
        d_b  = imm_u;
        d_we = 1'b1;
      end
      OPC_AUIPC: begin
        d_a  = pc;
        d_b  = imm_u;
        d_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_a   = pc;
        d_b   = XLEN'(4);
        d_we  = 1'b1;
        d_ill = (opcode == OPC_JALR) && (funct3 != 3'd0);
      end
      OPC_LOAD: begin
        d_a  = rs1_data;
        d_b  = imm_i;
        d_we = 1'b1;
        d_ld = 1'b1;
      end
      OPC_STORE: begin
        d_a  = rs1_data;
        d_b  = imm_s;
        d_st = 1'b1;
      end
      OPC_BRANCH: begin
        d_a  = rs1_data;
        d_b  = rs2_data;
        d_br = 1'b1;
        case (funct3[2:1])
          2'd0:    d_ctrl = ALU_SUB;
          2'd2:    d_ctrl = ALU_SLT;
          2'd3:    d_ctrl = ALU_SLTU;
          default: d_ill  = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal ops still issue so the exception reaches execute, but with no side effects.
    if (d_ill) begin
      d_ctrl = ALU_ADD;
      d_a    = '0;
      d_b    = '0;
      d_we   = 1'b0;
      d_ld   = 1'b0;
      d_st   = 1'b0;
      d_br   = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_ctrl   <= '0;
      data_A     <= '0;
      data_B     <= '0;
      store_data <= '0;
      rd_addr    <= '0;
      reg_write  <= 1'b0;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      is_branch  <= 1'b0;
      br_funct3  <= '0;
      illegal    <= 1'b0;
      pc_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_ctrl   <= d_ctrl;
      data_A     <= d_a;
      data_B     <= d_b;
      store_data <= rs2_data;
      rd_addr    <= d_we ? instr[11:7] : 5'd0;
      reg_write  <= d_we;
      is_load    <= d_ld;
      is_store   <= d_st;
      is_branch  <= d_br;
      br_funct3  <= funct3;
      illegal    <= d_ill;
      pc_out     <= pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
